// File: rtl/serial_tx_if.sv
// serial_tx_if: byte handshake between the packet send stage (master) and the
// UART transmitter (slave). DataNext is the transmitter's registered request
// for another byte; DataReady is a one-cycle strobe qualifying DataVal.
interface serial_tx_if;
   logic [7:0] DataVal;
   logic       DataReady;
   logic       DataNext;

   modport master (
      output DataVal,
      output DataReady,
      input  DataNext
   );

   modport slave (
      input  DataVal,
      input  DataReady,
      output DataNext
   );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: UART transmitter with a one-byte prefetch register.
// Bytes arrive over serial_tx_if, wait in the prefetch register and are
// shifted out LSB-first as start / 8 data / [parity] / stop frames on txd.
// A byte prefetched during the current frame is launched on the same edge
// that ends the last stop bit, so back-to-back frames carry no idle time.
// Optional feature: define UART_TX_PARITY_EN to add an even parity bit
// after data bit 7.
module serial_tx #(
   parameter int unsigned BAUD_DIV  = 16,  // clk cycles per bit time, 2..65535
   parameter int unsigned STOP_BITS = 1    // 1 or 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   serial_tx_if.slave up,
   output logic       txd,
   output logic       busy,
   output logic       frameDone
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PAR,
`endif
      ST_STOP
   } state_t;

   localparam logic [15:0] DIV_LOAD  = 16'(BAUD_DIV - 1);
   localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

   state_t      state;
   state_t      state_d;
   logic [7:0]  hold;
   logic        hold_full;
   logic        data_next;
   logic [7:0]  shift;
   logic [7:0]  shift_d;
   logic [15:0] div_cnt;
   logic [15:0] div_d;
   logic [2:0]  bit_idx;
   logic [2:0]  bit_d;
   logic        txd_q;
   logic        txd_d;
   logic        done_q;
   logic        done_d;
   logic        unload;
   logic        capture;
   logic        boundary;
`ifdef UART_TX_PARITY_EN
   logic        parity_q;
`endif

   // A byte is only taken while the prefetch register is empty; a strobe
   // arriving while it is full is a protocol error and the byte is dropped.
   assign capture  = up.DataReady & ~hold_full;
   assign boundary = (div_cnt == 16'd0);

   // Prefetch register and the registered request toward upstream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: hold data is cleared along with hold_full so no X can reach shift.
         hold      <= '0;
         hold_full <= 1'b0;
         data_next <= 1'b0;
      end else begin
         // NOTE: state registers use <= so every always_ff sees pre-edge values.
         data_next <= enable & ~hold_full & ~up.DataReady;
         if (capture) begin
            hold      <= up.DataVal;
            hold_full <= 1'b1;
         end else if (unload) begin
            hold_full <= 1'b0;
         end
      end
   end

   // Frame sequencer registers; txd and frameDone are registered copies of
   // the next-state decode so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         shift    <= '0;
         div_cnt  <= '0;
         bit_idx  <= '0;
         txd_q    <= 1'b1;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state    <= state_d;
         shift    <= shift_d;
         div_cnt  <= div_d;
         bit_idx  <= bit_d;
         txd_q    <= txd_d;
         done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
         if (unload) begin
            parity_q <= ^hold;
         end
`endif
      end
   end

   // Next-state, bit timer and serial line decode.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_d = state;
      shift_d = shift;
      div_d   = div_cnt;
      bit_d   = bit_idx;
      done_d  = 1'b0;
      unload  = 1'b0;
      txd_d   = 1'b1;

      if (state != ST_IDLE) begin
         div_d = boundary ? DIV_LOAD : div_cnt - 16'd1;
      end

      case (state)
         ST_IDLE: begin
            if (hold_full && enable) begin
               unload  = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (boundary) begin
               state_d = ST_DATA;
               bit_d   = 3'd0;
            end
         end
         ST_DATA: begin
            if (boundary) begin
               shift_d = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PAR;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d = bit_idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PAR: begin
            if (boundary) begin
               state_d = ST_STOP;
               bit_d   = 3'd0;
            end
         end
`endif
         ST_STOP: begin
            if (boundary) begin
               if (bit_idx == STOP_LAST) begin
                  done_d = 1'b1;
                  if (hold_full && enable) begin
                     unload  = 1'b1;
                     state_d = ST_START;
                  end else begin
                     state_d = ST_IDLE;
                     div_d   = '0;
                     bit_d   = 3'd0;
                  end
               end else begin
                  bit_d = bit_idx + 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            div_d   = '0;
            bit_d   = 3'd0;
         end
      endcase

      // Launching a frame reloads the shifter and restarts the bit timer.
      if (unload) begin
         shift_d = hold;
         div_d   = DIV_LOAD;
         bit_d   = 3'd0;
      end

      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PAR:   txd_d = parity_q;
`endif
         default:  txd_d = 1'b1;
      endcase
   end

   assign up.DataNext = data_next;
   assign txd         = txd_q;
   assign frameDone   = done_q;
   assign busy        = (state != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: randomized scoreboard bench for serial_tx.
// An upstream process answers DataNext with one-cycle strobes and pushes each
// accepted byte into a queue; an independent line monitor decodes txd sample
// by sample against the frame expected for the oldest queued byte.
module tb_serial_tx;
   localparam int BAUD = 4;
   localparam int STOP = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME_BITS = 10 + STOP - 1 + PAR_BITS;
   localparam int FRAME_CLKS = FRAME_BITS * BAUD;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic enable = 1'b1;
   logic txd;
   logic busy;
   logic frameDone;

   serial_tx_if up_if ();

   serial_tx #(.BAUD_DIV(BAUD), .STOP_BITS(STOP)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .up        (up_if),
      .txd       (txd),
      .busy      (busy),
      .frameDone (frameDone)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] src_q[$];
   logic [7:0] exp_q[$];
   bit         src_eager = 1'b1;

   // driver state
   bit         strobe_chk = 1'b0;
   int         n_strobes = 0;
   int         last_strobe_cyc = 0;
   logic [7:0] drv_byte;

   // monitor state
   bit          mon_busy = 1'b0;
   bit          done_pending = 1'b0;
   bit          gap_window = 1'b0;
   bit          last_gapless = 1'b0;
   int          mon_idx = 0;
   int          mon_bit = 0;
   int          mon_err = 0;
   int          mon_early = 0;
   logic [15:0] mon_exp = 16'hFFFF;
   logic [15:0] mon_rx = 16'hFFFF;
   logic [15:0] last_rx = 16'hFFFF;
   int          frames_started = 0;
   int          frames_done = 0;
   int          done_pulses = 0;
   int          last_start_cyc = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected line levels of one frame, bit 0 first: start, data LSB first,
   // optional even parity, then stop bits (all remaining positions high).
   function automatic logic [15:0] frame_bits(input logic [7:0] b);
      logic [15:0] f;
      f      = 16'hFFFF;
      f[0]   = 1'b0;
      f[8:1] = b;
      if (PAR_BITS != 0) f[9] = (($countones(b) % 2) == 1);
      return f;
   endfunction

   // Upstream model: strobe a queued byte whenever DataNext is seen high.
   initial begin : driver
      up_if.DataVal   = 8'h00;
      up_if.DataReady = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            up_if.DataReady = 1'b0;
            strobe_chk      = 1'b0;
         end else begin
            if (strobe_chk) begin
               check("data_next_after_strobe", up_if.DataNext, 0);
               strobe_chk = 1'b0;
            end
            up_if.DataReady = 1'b0;
            if (src_q.size() != 0 && up_if.DataNext &&
                (src_eager || $urandom_range(0, 2) == 0)) begin
               drv_byte        = src_q.pop_front();
               up_if.DataVal   = drv_byte;
               up_if.DataReady = 1'b1;
               exp_q.push_back(drv_byte);
               strobe_chk      = 1'b1;
               last_strobe_cyc = cyc;
               n_strobes++;
            end
         end
      end
   end

   // Line monitor: one sample per clk, every sample of every bit checked.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst) begin
            mon_busy     = 1'b0;
            done_pending = 1'b0;
         end else begin
            if (frameDone) done_pulses++;
            gap_window = 1'b0;
            if (done_pending) begin
               check("frame_done_pulse", frameDone, 1);
               done_pending = 1'b0;
               gap_window   = 1'b1;
            end
            if (!mon_busy && txd == 1'b0) begin
               check("frame_expected", exp_q.size() != 0, 1);
               mon_exp        = (exp_q.size() != 0) ? frame_bits(exp_q.pop_front()) : 16'hFFFF;
               mon_rx         = 16'hFFFF;
               mon_err        = 0;
               mon_early      = 0;
               mon_idx        = 0;
               mon_busy       = 1'b1;
               last_gapless   = gap_window;
               last_start_cyc = cyc;
               frames_started++;
            end
            if (mon_busy) begin
               mon_bit = mon_idx / BAUD;
               if (txd !== mon_exp[mon_bit]) mon_err++;
               if (mon_idx % BAUD == BAUD / 2) mon_rx[mon_bit] = txd;
               if (mon_idx != 0 && frameDone) mon_early++;
               mon_idx++;
               if (mon_idx == FRAME_CLKS) begin
                  check("frame_bits", mon_rx, mon_exp);
                  check("bit_timing_errors", mon_err, 0);
                  check("frame_done_early", mon_early, 0);
                  last_rx      = mon_rx;
                  mon_busy     = 1'b0;
                  done_pending = 1'b1;
                  frames_done++;
               end
            end
         end
      end
   end

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(src_q.size() == 0 && exp_q.size() == 0 && !mon_busy &&
                   !done_pending && !busy) && n < budget);
      check({name, "_drain_in_budget"}, n < budget, 1);
   endtask

   task automatic wait_bit(input int idx, input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(mon_busy && mon_idx == idx) && n < budget);
      check({name, "_reached_in_budget"}, n < budget, 1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "simulation time limit");
   end

   initial begin : stimulus
      int f0;
      int d0;
      int s0;
      int low_cnt;
      int dn_cnt;
      int idle_cnt;

      repeat (3) @(negedge clk);
      #1;
      check("reset_txd", txd, 1);
      check("reset_busy", busy, 0);
      check("reset_data_next", up_if.DataNext, 0);
      check("reset_frame_done", frameDone, 0);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("data_next_after_release", up_if.DataNext, 1);

      // Single 0xA5 frame: latency, line pattern and one frameDone pulse.
      d0 = done_pulses;
      src_q.push_back(8'hA5);
      wait_idle(400, "t1");
      check("t1_latency_clks", last_start_cyc - last_strobe_cyc, 2);
      check("t1_frame_done_count", done_pulses - d0, 1);
      check("t1_line_pattern", last_rx, (PAR_BITS != 0) ? 16'hFD4A : 16'hFF4A);

      // Eager upstream: 0x00 then 0xFF must go out gapless, two strobes only.
      s0 = n_strobes;
      f0 = frames_done;
      src_q.push_back(8'h00);
      src_q.push_back(8'hFF);
      wait_idle(400, "t2");
      check("t2_gapless", last_gapless, 1);
      check("t2_bytes_accepted", n_strobes - s0, 2);
      check("t2_frames", frames_done - f0, 2);

      // Drop enable in data bit 3 with a byte prefetched.
      src_q.push_back(8'h3A);
      src_q.push_back(8'hC5);
      wait_bit(4 * BAUD + 1, 400, "t4_bit3");
      check("t4_busy_with_hold", busy, 1);
      enable = 1'b0;
      f0 = 0;
      while ((mon_busy || done_pending) && f0 < 400) begin
         @(negedge clk);
         #1;
         f0++;
      end
      check("t4_frame_finished", mon_busy, 0);
      f0       = frames_started;
      low_cnt  = 0;
      dn_cnt   = 0;
      idle_cnt = 0;
      repeat (100) begin
         @(negedge clk);
         #1;
         if (!txd) low_cnt++;
         if (up_if.DataNext) dn_cnt++;
         if (!busy) idle_cnt++;
      end
      check("t4_txd_low_while_disabled", low_cnt, 0);
      check("t4_data_next_while_disabled", dn_cnt, 0);
      check("t4_not_busy_while_held", idle_cnt, 0);
      check("t4_frames_while_disabled", frames_started - f0, 0);
      enable = 1'b1;
      wait_idle(400, "t4");
      check("t4_held_byte_sent", frames_started - f0, 1);

      // Asynchronous reset in data bit 5, then a clean frame.
      src_q.push_back(8'h55);
      wait_bit(6 * BAUD + 1, 400, "t5_bit5");
      check("t5_txd_bit5", txd, 0);
      rst = 1'b0;
      #1;
      check("t5_async_txd", txd, 1);
      check("t5_async_data_next", up_if.DataNext, 0);
      check("t5_async_busy", busy, 0);
      repeat (2) @(negedge clk);
      exp_q.delete();
      src_q.delete();
      @(negedge clk);
      rst = 1'b1;
      f0 = frames_done;
      src_q.push_back(8'h3C);
      wait_idle(400, "t5");
      check("t5_clean_frame", frames_done - f0, 1);

      // Parity bytes 0x07 (odd count) then 0x03 (even count).
      f0 = frames_done;
      src_q.push_back(8'h07);
      src_q.push_back(8'h03);
      wait_idle(400, "t6");
      check("t6_frames", frames_done - f0, 2);
      check("t6_last_pattern", last_rx, (PAR_BITS != 0) ? 16'hFC06 : 16'hFE06);

      // Random bytes with a lazy upstream, then with an eager one.
      src_eager = 1'b0;
      for (int i = 0; i < 24; i++) src_q.push_back(8'($urandom));
      wait_idle(6000, "rand_lazy");
      src_eager = 1'b1;
      for (int i = 0; i < 10; i++) src_q.push_back(8'($urandom));
      wait_idle(3000, "rand_eager");

      // One frame was aborted by reset; every other accepted byte was sent.
      check("frames_vs_strobes", frames_done, n_strobes - 1);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end
endmodule
